// File: rtl/date_counter.sv
// date_counter: day-of-month / month calendar stage feeding the year counter's enable.
// Optional macro LEAP_YEAR_EN: February follows the Gregorian leap rule on the year input.
module date_counter #(
  parameter int unsigned RESET_DAY   = 1,
  parameter int unsigned RESET_MONTH = 1
) (
  input  logic        clk_1s,
  input  logic        rst,
  input  logic        day_tick,
  input  logic [11:0] year,
  input  logic        set_enable,
  input  logic        set_sel,
  input  logic        inc,
  input  logic        dec,
  output logic [4:0]  day,
  output logic [3:0]  month,
  output logic [3:0]  day_tens,
  output logic [3:0]  day_units,
  output logic [3:0]  month_tens,
  output logic [3:0]  month_units,
  output logic        year_tick
);

  logic [4:0] r_day;
  logic [3:0] r_month;
  logic       r_year_tick;
  logic       r_inc_q;
  logic       r_dec_q;

  logic       w_inc_p;
  logic       w_dec_p;
  logic       w_leap;
  logic [4:0] w_max_day;
  logic [4:0] w_day_eff;
  logic [3:0] w_new_month;
  logic [4:0] w_new_max;
  logic [4:0] w_day_nxt;
  logic [3:0] w_month_nxt;
  logic       w_year_tick_nxt;

  function automatic logic [4:0] f_max_day(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: f_max_day = 5'd30;
      4'd2:                    f_max_day = leap ? 5'd29 : 5'd28;
      default:                 f_max_day = 5'd31;
    endcase
  endfunction

`ifdef LEAP_YEAR_EN
  assign w_leap = (year[1:0] == 2'b00) &&
                  (((year % 12'd100) != 12'd0) || ((year % 12'd400) == 12'd0));
`else
  logic w_unused_year;
  assign w_unused_year = ^year;
  assign w_leap        = 1'b0;
`endif

  assign w_inc_p   = inc & ~r_inc_q;
  assign w_dec_p   = dec & ~r_dec_q;
  assign w_max_day = f_max_day(r_month, w_leap);
  // Day limited to the current month length; also serves as the idle clamp.
  assign w_day_eff = (r_day > w_max_day) ? w_max_day : r_day;

  assign w_new_month = w_inc_p ? ((r_month >= 4'd12) ? 4'd1  : r_month + 4'd1)
                               : ((r_month <= 4'd1)  ? 4'd12 : r_month - 4'd1);
  assign w_new_max   = f_max_day(w_new_month, w_leap);

  always_comb begin
    w_day_nxt       = w_day_eff;
    w_month_nxt     = r_month;
    w_year_tick_nxt = 1'b0;
    if (set_enable) begin
      if (w_inc_p ^ w_dec_p) begin
        if (!set_sel) begin
          if (w_inc_p) w_day_nxt = (w_day_eff == w_max_day) ? 5'd1 : w_day_eff + 5'd1;
          else         w_day_nxt = (w_day_eff <= 5'd1) ? w_max_day : w_day_eff - 5'd1;
        end else begin
          w_month_nxt = w_new_month;
          w_day_nxt   = (r_day > w_new_max) ? w_new_max : r_day;
        end
      end
    end else if (day_tick) begin
      if (w_day_eff < w_max_day) begin
        w_day_nxt = w_day_eff + 5'd1;
      end else begin
        w_day_nxt = 5'd1;
        if (r_month >= 4'd12) begin
          w_month_nxt     = 4'd1;
          w_year_tick_nxt = 1'b1;
        end else begin
          w_month_nxt = r_month + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_1s or posedge rst) begin
    if (rst) begin
      r_day       <= 5'(RESET_DAY);
      r_month     <= 4'(RESET_MONTH);
      r_year_tick <= 1'b0;
      r_inc_q     <= 1'b0;
      r_dec_q     <= 1'b0;
    end else begin
      r_day       <= w_day_nxt;
      r_month     <= w_month_nxt;
      r_year_tick <= w_year_tick_nxt;
      r_inc_q     <= inc;
      r_dec_q     <= dec;
    end
  end

  always_comb begin
    day_tens  = 4'd0;
    day_units = 4'(r_day);
    if (r_day >= 5'd30) begin
      day_tens  = 4'd3;
      day_units = 4'(r_day - 5'd30);
    end else if (r_day >= 5'd20) begin
      day_tens  = 4'd2;
      day_units = 4'(r_day - 5'd20);
    end else if (r_day >= 5'd10) begin
      day_tens  = 4'd1;
      day_units = 4'(r_day - 5'd10);
    end
  end

  assign month_tens  = (r_month >= 4'd10) ? 4'd1 : 4'd0;
  assign month_units = (r_month >= 4'd10) ? r_month - 4'd10 : r_month;
  assign day         = r_day;
  assign month       = r_month;
  assign year_tick   = r_year_tick;

endmodule

// File: tb/tb_date_counter.sv
// tb_date_counter: random and directed checks of date_counter against a
// day-of-year calendar model kept in the bench.
module tb_date_counter;

  logic        clk_1s = 1'b0;
  logic        rst;
  logic        day_tick;
  logic [11:0] year;
  logic        set_enable;
  logic        set_sel;
  logic        inc;
  logic        dec;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [3:0]  day_tens;
  logic [3:0]  day_units;
  logic [3:0]  month_tens;
  logic [3:0]  month_units;
  logic        year_tick;

  int total = 0;
  int bad   = 0;

  int m_day;
  int m_month;
  bit m_yt;
  bit m_inc_q;
  bit m_dec_q;

  logic [24:0] exp_q[$];

  date_counter dut (
    .clk_1s      (clk_1s),
    .rst         (rst),
    .day_tick    (day_tick),
    .year        (year),
    .set_enable  (set_enable),
    .set_sel     (set_sel),
    .inc         (inc),
    .dec         (dec),
    .day         (day),
    .month       (month),
    .day_tens    (day_tens),
    .day_units   (day_units),
    .month_tens  (month_tens),
    .month_units (month_units),
    .year_tick   (year_tick)
  );

  // clock / watchdog
  always #5 clk_1s = ~clk_1s;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog");
  end

  // calendar model: dates handled as ordinal day-of-year
  function automatic int month_len(int m, int y);
    int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int r;
    r = lens[m-1];
`ifdef LEAP_YEAR_EN
    if (m == 2 && (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0))) r = 29;
`endif
    return r;
  endfunction

  function automatic int year_len(int y);
    int s = 0;
    for (int k = 1; k <= 12; k++) s += month_len(k, y);
    return s;
  endfunction

  task automatic model_step();
    bit inc_p;
    bit dec_p;
    int mx;
    int eff;
    int ord;
    int nmx;
    if (rst) begin
      m_day = 1; m_month = 1; m_yt = 0; m_inc_q = 0; m_dec_q = 0;
      return;
    end
    inc_p = inc && !m_inc_q;
    dec_p = dec && !m_dec_q;
    mx    = month_len(m_month, int'(year));
    eff   = (m_day > mx) ? mx : m_day;
    m_yt  = 0;
    if (set_enable) begin
      if (inc_p != dec_p) begin
        if (!set_sel) begin
          m_day = inc_p ? (eff % mx) + 1 : ((eff + mx - 2) % mx) + 1;
        end else begin
          m_month = inc_p ? (m_month % 12) + 1 : ((m_month + 10) % 12) + 1;
          nmx = month_len(m_month, int'(year));
          if (m_day > nmx) m_day = nmx;
        end
      end else begin
        m_day = eff;
      end
    end else if (day_tick) begin
      ord = eff + 1;
      for (int k = 1; k < m_month; k++) ord += month_len(k, int'(year));
      if (ord > year_len(int'(year))) begin
        ord  = 1;
        m_yt = 1;
      end
      m_month = 1;
      while (ord > month_len(m_month, int'(year))) begin
        ord -= month_len(m_month, int'(year));
        m_month++;
      end
      m_day = ord;
    end else begin
      m_day = eff;
    end
    m_inc_q = inc;
    m_dec_q = dec;
  endtask

  // driver tasks
  task automatic tick_clk();
    @(posedge clk_1s);
    model_step();
    #1;
  endtask

  task automatic set_date(int d, int m);
    int guard = 0;
    set_enable = 1; day_tick = 0; inc = 0; dec = 0;
    set_sel = 1;
    while (m_month != m && guard < 40) begin
      inc = 1; tick_clk(); inc = 0; tick_clk(); guard++;
    end
    set_sel = 0;
    while (m_day != d && guard < 120) begin
      inc = 1; tick_clk(); inc = 0; tick_clk(); guard++;
    end
    set_enable = 0;
    total++;
    if (day !== 5'(d) || month !== 4'(m)) begin
      bad++;
      $display("FAIL set_date: got %0d/%0d want %0d/%0d", day, month, d, m);
    end
  endtask

  task automatic test_reset();
    rst = 1; day_tick = 0; year = 12'd2025; set_enable = 0; set_sel = 0; inc = 0; dec = 0;
    model_step();
    #1;
    total++;
    if (day !== 5'd1 || month !== 4'd1 || day_tens !== 4'd0 || day_units !== 4'd1 ||
        month_tens !== 4'd0 || month_units !== 4'd1 || year_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset: got d=%0d m=%0d du=%0d mu=%0d yt=%0b want 1 1 1 1 0",
               day, month, day_units, month_units, year_tick);
    end
    tick_clk();
    tick_clk();
    @(negedge clk_1s);
    rst = 0;
    tick_clk();
  endtask

  task automatic test_month_advance();
    day_tick = 1;
    repeat (30) tick_clk();
    total++;
    if (day !== 5'd31 || month !== 4'd1 || day_tens !== 4'd3 || day_units !== 4'd1) begin
      bad++;
      $display("FAIL jan31: got %0d/%0d bcd %0d%0d want 31/1", day, month, day_tens, day_units);
    end
    tick_clk();
    day_tick = 0;
    total++;
    if (day !== 5'd1 || month !== 4'd2 || year_tick !== 1'b0) begin
      bad++;
      $display("FAIL feb01: got %0d/%0d yt=%0b want 1/2 yt=0", day, month, year_tick);
    end
  endtask

  task automatic test_leap();
    int exp_d;
    int exp_m;
    year = 12'd2028;
    set_date(28, 2);
    day_tick = 1;
    tick_clk();
`ifdef LEAP_YEAR_EN
    exp_d = 29; exp_m = 2;
`else
    exp_d = 1;  exp_m = 3;
`endif
    total++;
    if (day !== 5'(exp_d) || month !== 4'(exp_m)) begin
      bad++;
      $display("FAIL leap_2028: got %0d/%0d want %0d/%0d", day, month, exp_d, exp_m);
    end
`ifdef LEAP_YEAR_EN
    tick_clk();
    total++;
    if (day !== 5'd1 || month !== 4'd3) begin
      bad++;
      $display("FAIL leap_mar01: got %0d/%0d want 1/3", day, month);
    end
    // 29-Feb then a year change to a non-leap year clamps to 28 on an idle cycle
    set_date(29, 2);
    year = 12'd2029;
    tick_clk();
    total++;
    if (day !== 5'd28 || month !== 4'd2) begin
      bad++;
      $display("FAIL clamp: got %0d/%0d want 28/2", day, month);
    end
`endif
    day_tick = 0;
    year = 12'd2100;
    set_date(28, 2);
    day_tick = 1;
    tick_clk();
    day_tick = 0;
    total++;
    if (day !== 5'd1 || month !== 4'd3) begin
      bad++;
      $display("FAIL century_2100: got %0d/%0d want 1/3", day, month);
    end
  endtask

  task automatic test_rollover();
    year = 12'd2030;
    set_date(31, 12);
    total++;
    if (year_tick !== 1'b0 || day_tens !== 4'd3 || month_tens !== 4'd1 || month_units !== 4'd2) begin
      bad++;
      $display("FAIL dec31: got yt=%0b dt=%0d mt=%0d mu=%0d want 0 3 1 2",
               year_tick, day_tens, month_tens, month_units);
    end
    day_tick = 1;
    tick_clk();
    day_tick = 0;
    total++;
    if (day !== 5'd1 || month !== 4'd1 || year_tick !== 1'b1) begin
      bad++;
      $display("FAIL newyear: got %0d/%0d yt=%0b want 1/1 yt=1", day, month, year_tick);
    end
    tick_clk();
    total++;
    if (year_tick !== 1'b0) begin
      bad++;
      $display("FAIL yt_width: got yt=%0b want 0", year_tick);
    end
    // second rollover, then asynchronous reset while year_tick is high
    set_date(31, 12);
    day_tick = 1;
    tick_clk();
    day_tick = 0;
    rst = 1;
    model_step();
    #1;
    total++;
    if (year_tick !== 1'b0 || day !== 5'd1 || month !== 4'd1) begin
      bad++;
      $display("FAIL async_rst: got %0d/%0d yt=%0b want 1/1 yt=0", day, month, year_tick);
    end
    tick_clk();
    @(negedge clk_1s);
    rst = 0;
    tick_clk();
  endtask

  task automatic test_set_edges();
    year = 12'd2027;
    set_date(31, 3);
    set_enable = 1; set_sel = 1; dec = 1;
    tick_clk();
    dec = 0;
    total++;
    if (day !== 5'd28 || month !== 4'd2 || year_tick !== 1'b0) begin
      bad++;
      $display("FAIL set_dec_clamp: got %0d/%0d yt=%0b want 28/2 yt=0", day, month, year_tick);
    end
    tick_clk();
    inc = 1;
    repeat (5) tick_clk();
    inc = 0;
    tick_clk();
    total++;
    if (day !== 5'd28 || month !== 4'd3) begin
      bad++;
      $display("FAIL inc_held: got %0d/%0d want 28/3", day, month);
    end
    set_sel = 0; inc = 1; dec = 1;
    tick_clk();
    inc = 0; dec = 0;
    total++;
    if (day !== 5'd28 || month !== 4'd3) begin
      bad++;
      $display("FAIL inc_dec_both: got %0d/%0d want 28/3", day, month);
    end
    set_date(1, 3);
    set_enable = 1; set_sel = 0; dec = 1;
    tick_clk();
    dec = 0;
    total++;
    if (day !== 5'd31 || month !== 4'd3) begin
      bad++;
      $display("FAIL day_dec_wrap: got %0d/%0d want 31/3", day, month);
    end
    day_tick = 1;
    tick_clk();
    day_tick = 0;
    set_enable = 0;
    total++;
    if (day !== 5'd31 || month !== 4'd3 || year_tick !== 1'b0) begin
      bad++;
      $display("FAIL set_freeze: got %0d/%0d yt=%0b want 31/3 yt=0", day, month, year_tick);
    end
  endtask

  task automatic test_random();
    logic [24:0] got;
    logic [24:0] exp;
    set_date(1, 11);
    for (int i = 0; i < 600; i++) begin
      set_enable = ($urandom_range(0, 3) == 0);
      set_sel    = 1'($urandom_range(0, 1));
      inc        = 1'($urandom_range(0, 1));
      dec        = 1'($urandom_range(0, 1));
      day_tick   = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 19) == 0) year = 12'($urandom_range(2025, 2999));
      tick_clk();
      exp_q.push_back({m_yt, 5'(m_day), 4'(m_month), 4'(m_day / 10), 4'(m_day % 10),
                       4'(m_month / 10), 4'(m_month % 10)});
      got = {year_tick, day, month, day_tens, day_units, month_tens, month_units};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random[%0d]: got yt=%0b %0d/%0d want yt=%0b %0d/%0d (raw %h vs %h)",
                 i, got[24], got[23:19], got[18:15], exp[24], exp[23:19], exp[18:15], got, exp);
      end
    end
    set_enable = 0; inc = 0; dec = 0; day_tick = 0;
  endtask

  initial begin
    test_reset();
    test_month_advance();
    test_leap();
    test_rollover();
    test_set_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
